// File: rtl/axi_pkg.sv
// axi_pkg: AXI4 encodings and bridge FSM states shared by the master bridge.
package axi_pkg;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_8B    = 3'd3;

    typedef enum logic [2:0] {IDLE, AR, R, WR, B} state_t;

    function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
        return len > max_len ? max_len : len;
    endfunction
endpackage

// File: rtl/axi_master_bridge.sv
// axi_master_bridge: simple request port to AXI4 master, one transaction in flight,
// read bursts streamed back per R beat, single-beat writes completed on B.
module axi_master_bridge
    import axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID  = 4'd0,
    parameter logic [7:0] MAX_LEN = 8'd7
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_last,
    output logic        resp_err,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    state_t      st;
    logic [7:0]  cnt, len;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        r_beat, b_beat;

    assign araddr  = addr;
    assign arid    = AXI_ID;
    assign arlen   = len;
    assign arsize  = size;
    assign arburst = BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = AXI_ID;
    assign awaddr  = addr;
    assign awlen   = 8'd0;
    assign awsize  = size;
    assign awburst = BURST_INCR;
    assign awlock  = 1'b0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = AXI_ID;
    assign wlast   = 1'b1;

    // Responses pass straight through from R/B so the requester sees no extra latency.
    assign r_beat     = st == R && rvalid;
    assign b_beat     = st == B && bvalid;
    assign resp_valid = r_beat | b_beat;
    assign resp_rdata = r_beat ? rdata : 64'd0;
    assign resp_last  = r_beat ? rlast : b_beat;
    assign resp_err   = r_beat ? (rresp != RESP_OKAY || rid != AXI_ID || rlast != (cnt == len))
                               : b_beat && (bresp != RESP_OKAY || bid != AXI_ID);

    always_ff @(posedge aclk) begin
        if (areset) begin
            st        <= IDLE;
            req_ready <= 1'b0;
            arvalid   <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            rready    <= 1'b0;
            bready    <= 1'b0;
            cnt       <= 8'd0;
            len       <= 8'd0;
            addr      <= 32'd0;
            size      <= 3'd0;
            wdata     <= 64'd0;
            wstrb     <= 8'd0;
        end else begin
            case (st)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr      <= req_addr;
                        size      <= req_size;
                        len       <= clamp_len(req_len, MAX_LEN);
                        wdata     <= req_wdata;
                        wstrb     <= req_wstrb;
                        arvalid   <= !req_wen;
                        awvalid   <= req_wen;
                        wvalid    <= req_wen;
                        st        <= req_wen ? WR : AR;
                    end
                end
                AR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    cnt     <= 8'd0;
                    st      <= R;
                end
                R: if (rvalid) begin
                    cnt <= cnt + 8'd1;
                    if (rlast) begin
                        rready    <= 1'b0;
                        req_ready <= 1'b1;
                        st        <= IDLE;
                    end
                end
                WR: begin
                    // A low valid in WR means that channel's handshake already happened.
                    if (awready) awvalid <= 1'b0;
                    if (wready) wvalid <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        st     <= B;
                    end
                end
                B: if (bvalid) begin
                    bready    <= 1'b0;
                    req_ready <= 1'b1;
                    st        <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_master_bridge.sv
// tb_axi_master_bridge: directed AXI slave stimulus with a per-cycle response model.
module tb_axi_master_bridge;
    logic        aclk = 0, areset = 1;
    logic        req_valid = 0, req_wen = 0;
    logic [31:0] req_addr = 0;
    logic [7:0]  req_len = 0;
    logic [2:0]  req_size = 0;
    logic [63:0] req_wdata = 0;
    logic [7:0]  req_wstrb = 0;
    logic        req_ready, resp_valid, resp_last, resp_err;
    logic [63:0] resp_rdata;
    logic [31:0] araddr, awaddr;
    logic [3:0]  arid, arcache, awid, awcache, wid;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, awburst;
    logic        arlock, arvalid, awlock, awvalid, wlast, wvalid, rready, bready;
    logic [63:0] wdata;
    logic        arready = 0, rlast = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
    logic [3:0]  rid = 0, bid = 0;
    logic [63:0] rdata = 0;
    logic [1:0]  rresp = 0, bresp = 0;

    logic        exp_valid = 0, exp_last = 0, exp_err = 0;
    logic [63:0] exp_data = 0, last_data = 0;
    int          checks = 0, failures = 0, n_resp = 0, n_err = 0;

    axi_master_bridge dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_last(resp_last), .resp_err(resp_err),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Expected read error: bad response code, wrong ID, or rlast not on beat min(len,7).
    function automatic logic beat_err(int idx, logic [7:0] len, logic rl, logic [1:0] rr, logic [3:0] id);
        int eff = len > 8'd7 ? 7 : int'(len);
        return rr != 2'b00 || id != 4'd0 || (rl != (idx == eff));
    endfunction

    always @(negedge aclk) begin
        checks++;
        if (resp_valid !== exp_valid) begin
            failures++;
            $display("FAIL resp_valid t=%0t got=%0b exp=%0b", $time, resp_valid, exp_valid);
        end else if (exp_valid) begin
            checks++;
            if (resp_rdata !== exp_data || resp_last !== exp_last || resp_err !== exp_err) begin
                failures++;
                $display("FAIL resp_beat t=%0t got data=%h last=%0b err=%0b exp data=%h last=%0b err=%0b",
                         $time, resp_rdata, resp_last, resp_err, exp_data, exp_last, exp_err);
            end
        end
        if (resp_valid === 1'b1) begin
            n_resp++;
            n_err += int'(resp_err);
            last_data = resp_rdata;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic issue(input logic wen, input logic [31:0] a, input logic [7:0] l,
                         input logic [63:0] wd, input logic [7:0] ws);
        for (int k = 0; k < 50 && !req_ready; k++) tick();
        chk("req_ready_wait", req_ready, 1);
        req_valid = 1; req_wen = wen; req_addr = a; req_len = l;
        req_size = 3'd3; req_wdata = wd; req_wstrb = ws;
        tick();
        req_valid = 0;
    endtask

    task automatic read_txn(input logic [31:0] a, input logic [7:0] l, input int rlast_idx,
                            input int err_idx, input int abort_idx);
        issue(0, a, l, 64'd0, 8'd0);
        chk("ar_latency", arvalid, 1);
        chk("arlen", arlen, l > 8'd7 ? 64'd7 : 64'(l));
        chk("araddr", araddr, a);
        chk("arsize_burst", {arsize, arburst}, {3'd3, 2'b01});
        rvalid = 1; rdata = 64'hBAD; rlast = 1;
        tick();
        rvalid = 0; rlast = 0;
        chk("ar_hold", {arvalid, araddr}, {1'b1, a});
        arready = 1;
        tick();
        arready = 0;
        chk("ar_done", {arvalid, rready}, 2'b01);
        for (int i = 0; i < 16; i++) begin
            rvalid = 1; rid = 0; rdata = 64'h11 * (i + 1); rlast = (i == rlast_idx);
            rresp = (i == err_idx) ? 2'b10 : 2'b00;
            exp_valid = 1; exp_data = rdata; exp_last = rlast;
            exp_err = beat_err(i, l, rlast, rresp, rid);
            if (i == abort_idx) areset = 1;
            tick();
            rvalid = 0; rlast = 0; rresp = 0; exp_valid = 0;
            if (i == abort_idx) begin
                chk("abort_valids", {arvalid, awvalid, wvalid, rready, bready, req_ready}, 6'd0);
                areset = 0;
                tick();
                chk("abort_ready", req_ready, 1);
                return;
            end
            if (i == rlast_idx) break;
        end
        chk("read_done_idle", {req_ready, rready}, 2'b10);
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [63:0] wd, input logic [7:0] ws,
                             input int aw_delay, input int w_delay, input logic [1:0] br, input logic [3:0] bi);
        int aw_hi = 0, w_hi = 0;
        issue(1, a, 8'd5, wd, ws);
        chk("aw_w_valid", {awvalid, wvalid}, 2'b11);
        chk("aw_fields", {awaddr, awlen, wlast}, {a, 8'd0, 1'b1});
        chk("w_fields", {wdata, wstrb}, {wd, ws});
        for (int c = 0; c < 20 && (awvalid || wvalid); c++) begin
            aw_hi += int'(awvalid);
            w_hi += int'(wvalid);
            awready = (c >= aw_delay);
            wready = (c >= w_delay);
            tick();
        end
        awready = 0; wready = 0;
        chk("aw_cycles", aw_hi, aw_delay + 1);
        chk("w_cycles", w_hi, w_delay + 1);
        chk("bready", bready, 1);
        bvalid = 1; bresp = br; bid = bi;
        exp_valid = 1; exp_data = 0; exp_last = 1; exp_err = (br != 2'b00 || bi != 4'd0);
        tick();
        bvalid = 0; bresp = 0; bid = 0; exp_valid = 0;
        chk("write_done_idle", {req_ready, bready}, 2'b10);
    endtask

    initial begin
        int r0, e0;
        tick(); tick(); tick();
        chk("reset_ready", req_ready, 0);
        chk("reset_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 6'd0);
        areset = 0;
        tick();
        chk("ready_post_reset", req_ready, 1);

        r0 = n_resp; e0 = n_err;
        read_txn(32'h8000_0000, 8'd7, 7, -1, -1);
        chk("rd8_beats", n_resp - r0, 8);
        chk("rd8_errs", n_err - e0, 0);
        chk("rd8_last_data", last_data, 64'h88);

        r0 = n_resp; e0 = n_err;
        write_txn(32'h8000_0010, 64'hDEADBEEF_CAFEF00D, 8'h0F, 3, 0, 2'b00, 4'd0);
        chk("wr_resp", n_resp - r0, 1);
        chk("wr_errs", n_err - e0, 0);

        r0 = n_resp; e0 = n_err;
        read_txn(32'h8000_0040, 8'd3, 1, -1, -1);
        chk("early_beats", n_resp - r0, 2);
        chk("early_errs", n_err - e0, 1);

        r0 = n_resp; e0 = n_err;
        read_txn(32'h8000_0060, 8'd1, 2, -1, -1);
        chk("late_beats", n_resp - r0, 3);
        chk("late_errs", n_err - e0, 2);

        r0 = n_resp; e0 = n_err;
        read_txn(32'h8000_0080, 8'd3, 3, 2, -1);
        chk("rresp_errs", n_err - e0, 1);

        e0 = n_err;
        write_txn(32'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 2, 2'b10, 4'd0);
        chk("bresp_err", n_err - e0, 1);
        e0 = n_err;
        write_txn(32'h8000_0028, 64'h55, 8'h01, 1, 1, 2'b00, 4'd3);
        chk("bid_err", n_err - e0, 1);

        r0 = n_resp;
        read_txn(32'h8000_0100, 8'd7, 7, -1, 2);
        chk("abort_beats", n_resp - r0, 3);
        r0 = n_resp; e0 = n_err;
        read_txn(32'h8000_0200, 8'd7, 7, -1, -1);
        chk("post_abort_beats", n_resp - r0, 8);
        chk("post_abort_errs", n_err - e0, 0);

        r0 = n_resp; e0 = n_err;
        read_txn(32'h8000_0300, 8'd20, 7, -1, -1);
        chk("clamp_beats", n_resp - r0, 8);
        chk("clamp_errs", n_err - e0, 0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
